oam_dma_ctrl: RTL

Sprite DMA sequencer for CPU register $4014. A CPU write to that address halts the CPU via RDY. The block then copies LEN bytes from CPU page {page,8'h00} into OAM, one read cycle followed by one write cycle per byte, using the same OAM write path as $2004 writes. It sits between the CPU bus and the PPU register interface and owns the CPU bus while active.

---
 rtl/oam_dma_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA sequencer for the $4014 register: halts the CPU and copies LEN bytes of a CPU page
// into OAM. Optional status outputs (dma_count, dma_done) are built when OAM_DMA_STATUS_EN is set.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter int unsigned LEN          = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_ce,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rw,
    output logic        cpu_rdy,
    output logic        dma_active,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  oam_data,
`ifdef OAM_DMA_STATUS_EN
    output logic [8:0]  dma_count,
    output logic        dma_done,
`endif
    output logic        oam_we
);

    typedef enum logic [2:0] {StIdle, StHalt, StAlign, StRead, StWrite, StDone} state_t;

    localparam logic [8:0] LastCount = 9'(LEN - 1);

    state_t      state_q, state_d;
    logic        parity_q, parity_d;
    logic [7:0]  page_q, page_d;
    logic [8:0]  count_q, count_d;
    logic        cpu_rdy_q, cpu_rdy_d;
    logic        dma_active_q, dma_active_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        mem_rd_q, mem_rd_d;
    logic [7:0]  oam_data_q, oam_data_d;
    logic        oam_we_q, oam_we_d;
`ifdef OAM_DMA_STATUS_EN
    logic        dma_done_q, dma_done_d;
`endif

    always_comb begin
        state_d      = state_q;
        parity_d     = parity_q ^ cpu_ce;
        page_d       = page_q;
        count_d      = count_q;
        cpu_rdy_d    = cpu_rdy_q;
        dma_active_d = dma_active_q;
        mem_addr_d   = mem_addr_q;
        mem_rd_d     = mem_rd_q;
        oam_data_d   = oam_data_q;
        oam_we_d     = 1'b0;
`ifdef OAM_DMA_STATUS_EN
        dma_done_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (cpu_ce && cpu_we && (cpu_addr == DMA_REG_ADDR)) begin
                    page_d    = cpu_wdata;
                    count_d   = 9'd0;
                    cpu_rdy_d = 1'b0;
                    state_d   = StHalt;
                end
            end
            StHalt: begin
                // CPU write cycles cannot be halted; wait for its stalled read.
                if (cpu_ce && cpu_rw) begin
                    dma_active_d = 1'b1;
                    state_d      = StAlign;
                end
            end
            StAlign: begin
                // Leave only when the next CPU cycle is a get cycle.
                if (cpu_ce && parity_q) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = {page_q, count_q[7:0]};
                    state_d    = StRead;
                end
            end
            StRead: begin
                if (cpu_ce) begin
                    oam_data_d = mem_rdata;
                    mem_rd_d   = 1'b0;
                    state_d    = StWrite;
                end
            end
            StWrite: begin
                if (cpu_ce) begin
                    oam_we_d = 1'b1;
                    count_d  = count_q + 9'd1;
                    if (count_q == LastCount) begin
`ifdef OAM_DMA_STATUS_EN
                        dma_done_d = 1'b1;
`endif
                        state_d = StDone;
                    end else begin
                        mem_rd_d   = 1'b1;
                        mem_addr_d = {page_q, count_d[7:0]};
                        state_d    = StRead;
                    end
                end
            end
            StDone: begin
                cpu_rdy_d    = 1'b1;
                dma_active_d = 1'b0;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            parity_q     <= 1'b0;
            page_q       <= 8'd0;
            count_q      <= 9'd0;
            cpu_rdy_q    <= 1'b1;
            dma_active_q <= 1'b0;
            mem_addr_q   <= 16'd0;
            mem_rd_q     <= 1'b0;
            oam_data_q   <= 8'd0;
            oam_we_q     <= 1'b0;
`ifdef OAM_DMA_STATUS_EN
            dma_done_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            parity_q     <= parity_d;
            page_q       <= page_d;
            count_q      <= count_d;
            cpu_rdy_q    <= cpu_rdy_d;
            dma_active_q <= dma_active_d;
            mem_addr_q   <= mem_addr_d;
            mem_rd_q     <= mem_rd_d;
            oam_data_q   <= oam_data_d;
            oam_we_q     <= oam_we_d;
`ifdef OAM_DMA_STATUS_EN
            dma_done_q   <= dma_done_d;
`endif
        end
    end

    assign cpu_rdy    = cpu_rdy_q;
    assign dma_active = dma_active_q;
    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign oam_data   = oam_data_q;
    assign oam_we     = oam_we_q;
`ifdef OAM_DMA_STATUS_EN
    assign dma_count  = count_q;
    assign dma_done   = dma_done_q;
`endif

endmodule
